hiss_lvds_ctrl: RTL and testbench
=================================

HISS_LVDS_CTRL -- requirements
Module: hiss_lvds_ctrl

Interface
REQ-001 The block SHALL have one clock, pclk, and one reset, n_p_reset; reset SHALL be asynchronous and active-low.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- BIAS_WAIT, 16, cycles spent in BIAS; legal 1..255.
- CLK_WAIT, 8, cycles spent in CLKUP; legal 1..255.
- DRAIN_WAIT, 4, cycles spent in DRAIN; legal 1..255.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- pclk in 1: clock.
- n_p_reset in 1: async active-low reset.
- en_req in 1: level request to power up the HISS LVDS pad.
- rx_i_req in 1: request for the RX I path.
- rx_q_req in 1: request for the RX Q path.
- tx_i_req in 1: request for the TX I path.
- tx_q_req in 1: request for the TX Q path.
- hiss_biasen out 1: pad bias enable.
- hiss_replien out 1: pad replica enable.
- hiss_curr out 1: pad driver current enable.
- hiss_clken out 1: pad clock receiver enable.
- hiss_rxien out 1: RX I receiver enable.
- hiss_rxqen out 1: RX Q receiver enable.
- hiss_txien out 1: TX I driver enable.
- hiss_txqen out 1: TX Q driver enable.
- ready out 1: pad is in ACTIVE.
- up_done out 1: one-cycle pulse on entry to ACTIVE.
- down_done out 1: one-cycle pulse on entry to OFF from DRAIN.
- state out 3: current FSM state.

Function
REQ-004 The FSM SHALL use these state encodings: OFF=0, BIAS=1, CLKUP=2, ACTIVE=3, DRAIN=4; the encodings 5..7 SHALL go to OFF on the next edge.
REQ-005 Every output SHALL be driven directly from a flop, registered from the next-state and next-input values, so that each output is valid in the first cycle of the new state.
REQ-006 An 8-bit down-counter SHALL load (WAIT-1) on entry to BIAS, CLKUP or DRAIN; the state SHALL advance on the edge where the counter is 0, so the state lasts exactly WAIT cycles.
REQ-007 In OFF, all enables, ready and both pulses SHALL be 0; en_req=1 at an edge SHALL move the FSM to BIAS on that edge.
REQ-008 In BIAS, hiss_biasen, hiss_replien and hiss_curr SHALL be 1 and all other enables 0.
- Count expiry SHALL move the FSM to CLKUP.
- en_req=0 SHALL move the FSM directly to OFF and SHALL NOT pulse down_done.
REQ-009 In CLKUP, the BIAS outputs SHALL be 1 and hiss_clken SHALL be 1.
- Count expiry SHALL move the FSM to ACTIVE.
- en_req=0 SHALL move the FSM to DRAIN.
REQ-010 In ACTIVE, the CLKUP outputs SHALL remain 1, ready SHALL be 1, and each enable SHALL follow its request:
- hiss_rxien=rx_i_req, hiss_rxqen=rx_q_req, hiss_txien=tx_i_req, hiss_txqen=tx_q_req.
- Each enable SHALL update one cycle after its request changes.
REQ-011 In ACTIVE, en_req=0 SHALL move the FSM to DRAIN, and the rx/tx enables SHALL drop on that same edge regardless of the request inputs.
REQ-012 In DRAIN, rx/tx enables and ready SHALL be 0, while hiss_clken and the bias outputs SHALL be 1; count expiry SHALL move the FSM to OFF.
REQ-013 DRAIN SHALL run to completion even if en_req returns to 1; the FSM SHALL pass through OFF for one cycle and then re-enter BIAS.
REQ-014 up_done SHALL be 1 only in the first ACTIVE cycle, and down_done only in the first OFF cycle after DRAIN.
REQ-015 rx/tx requests SHALL be ignored in every state except ACTIVE, and SHALL have no effect on state transitions.

Reset
REQ-016 Assertion of n_p_reset SHALL immediately force the FSM to OFF, the counter to 0 and every output to 0, including mid-sequence and in ACTIVE.
REQ-017 After reset is released, the FSM SHALL act on en_req at the first pclk rising edge.

Verification
REQ-018 Power-up, defaults, en_req held 1 from cycle 0 -> BIAS for cycles 1-16, CLKUP for cycles 17-24, ACTIVE from cycle 25 with up_done=1 only in cycle 25 and ready=1 from cycle 25.
REQ-019 In ACTIVE, raise rx_i_req and tx_q_req at cycle N -> hiss_rxien=1 and hiss_txqen=1 at N+1, hiss_rxqen=0 and hiss_txien=0; drop en_req -> all four enables 0 on the next cycle, DRAIN for 4 cycles, then OFF with down_done=1 for 1 cycle and hiss_clken=hiss_biasen=0.
REQ-020 Drop en_req on the 5th cycle of BIAS -> next cycle is OFF, all outputs 0, down_done stays 0; drop en_req in CLKUP -> DRAIN for 4 cycles, then OFF.
REQ-021 Reassert en_req during DRAIN -> DRAIN completes, 1 cycle in OFF, then BIAS, then a full sequence back to ACTIVE.
REQ-022 Assert n_p_reset asynchronously in ACTIVE, between clock edges -> all outputs 0 and state=0 immediately; after release with en_req=1 -> the full BIAS/CLKUP timing repeats.
REQ-023 Set BIAS_WAIT=CLK_WAIT=DRAIN_WAIT=1 -> each timed state lasts exactly 1 cycle.

Source files
------------

// File: rtl/hiss_lvds_if.sv
// Request/enable bundle between the HISS LVDS pad controller and its user.
// The master raises requests; the slave (the controller) drives the pad enables and status.
interface hiss_lvds_if;
    logic       en_req;
    logic       rx_i_req;
    logic       rx_q_req;
    logic       tx_i_req;
    logic       tx_q_req;
    logic       hiss_biasen;
    logic       hiss_replien;
    logic       hiss_curr;
    logic       hiss_clken;
    logic       hiss_rxien;
    logic       hiss_rxqen;
    logic       hiss_txien;
    logic       hiss_txqen;
    logic       ready;
    logic       up_done;
    logic       down_done;
    logic [2:0] state;

    modport master (
        output en_req, rx_i_req, rx_q_req, tx_i_req, tx_q_req,
        input  hiss_biasen, hiss_replien, hiss_curr, hiss_clken,
               hiss_rxien, hiss_rxqen, hiss_txien, hiss_txqen,
               ready, up_done, down_done, state
    );

    modport slave (
        input  en_req, rx_i_req, rx_q_req, tx_i_req, tx_q_req,
        output hiss_biasen, hiss_replien, hiss_curr, hiss_clken,
               hiss_rxien, hiss_rxqen, hiss_txien, hiss_txqen,
               ready, up_done, down_done, state
    );
endinterface

// File: rtl/hiss_lvds_ctrl.sv
// HISS LVDS pad power sequencer: OFF -> BIAS -> CLKUP -> ACTIVE -> DRAIN -> OFF.
// All outputs are flops loaded from the next state, so they are valid in the first cycle of a state.
module hiss_lvds_ctrl #(
    parameter int BIAS_WAIT  = 16,
    parameter int CLK_WAIT   = 8,
    parameter int DRAIN_WAIT = 4
) (
    input logic         pclk,
    input logic         n_p_reset,
    hiss_lvds_if.slave  bus
);

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        BIAS   = 3'd1,
        CLKUP  = 3'd2,
        ACTIVE = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    localparam logic [7:0] BIAS_LOAD  = 8'(BIAS_WAIT - 1);
    localparam logic [7:0] CLK_LOAD   = 8'(CLK_WAIT - 1);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_WAIT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       bias_d;
    logic       clk_d;
    logic       ready_d;
    logic       up_d;
    logic       down_d;
    logic [3:0] path_d;

    always_comb begin
        state_d = OFF;
        cnt_d   = 8'd0;
        bias_d  = 1'b0;
        clk_d   = 1'b0;
        ready_d = 1'b0;
        up_d    = 1'b0;
        down_d  = 1'b0;
        path_d  = 4'b0000;

        // Dropping en_req aborts BIAS straight to OFF but must drain once the clock is up.
        case (state_q)
            OFF:     state_d = bus.en_req ? BIAS : OFF;
            BIAS: begin
                if (!bus.en_req)          state_d = OFF;
                else if (cnt_q == 8'd0)   state_d = CLKUP;
                else                      state_d = BIAS;
            end
            CLKUP: begin
                if (!bus.en_req)          state_d = DRAIN;
                else if (cnt_q == 8'd0)   state_d = ACTIVE;
                else                      state_d = CLKUP;
            end
            ACTIVE:  state_d = bus.en_req ? ACTIVE : DRAIN;
            DRAIN:   state_d = (cnt_q == 8'd0) ? OFF : DRAIN;
            default: state_d = OFF;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                BIAS:    cnt_d = BIAS_LOAD;
                CLKUP:   cnt_d = CLK_LOAD;
                DRAIN:   cnt_d = DRAIN_LOAD;
                default: cnt_d = 8'd0;
            endcase
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end

        bias_d  = (state_d == BIAS) || (state_d == CLKUP) ||
                  (state_d == ACTIVE) || (state_d == DRAIN);
        clk_d   = (state_d == CLKUP) || (state_d == ACTIVE) || (state_d == DRAIN);
        ready_d = (state_d == ACTIVE);
        up_d    = (state_d == ACTIVE) && (state_q != ACTIVE);
        down_d  = (state_d == OFF) && (state_q == DRAIN);
        if (state_d == ACTIVE)
            path_d = {bus.rx_i_req, bus.rx_q_req, bus.tx_i_req, bus.tx_q_req};
    end

    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            state_q          <= OFF;
            cnt_q            <= 8'd0;
            bus.hiss_biasen  <= 1'b0;
            bus.hiss_replien <= 1'b0;
            bus.hiss_curr    <= 1'b0;
            bus.hiss_clken   <= 1'b0;
            bus.hiss_rxien   <= 1'b0;
            bus.hiss_rxqen   <= 1'b0;
            bus.hiss_txien   <= 1'b0;
            bus.hiss_txqen   <= 1'b0;
            bus.ready        <= 1'b0;
            bus.up_done      <= 1'b0;
            bus.down_done    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            bus.hiss_biasen  <= bias_d;
            bus.hiss_replien <= bias_d;
            bus.hiss_curr    <= bias_d;
            bus.hiss_clken   <= clk_d;
            bus.hiss_rxien   <= path_d[3];
            bus.hiss_rxqen   <= path_d[2];
            bus.hiss_txien   <= path_d[1];
            bus.hiss_txqen   <= path_d[0];
            bus.ready        <= ready_d;
            bus.up_done      <= up_d;
            bus.down_done    <= down_d;
        end
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_hiss_lvds_ctrl.sv
// Scoreboard bench for hiss_lvds_ctrl: one instance with default waits, one with all waits = 1.
// Stimulus pushes the hand-computed post-edge output vector; monitors pop and compare after each edge.
module tb_hiss_lvds_ctrl;

    typedef struct {
        logic [13:0] v;
        string       name;
    } exp_t;

    logic pclk;
    logic n_p_reset;
    int   vectors;
    int   miscompares;
    exp_t qa[$];
    exp_t qb[$];

    hiss_lvds_if ifa ();
    hiss_lvds_if ifb ();

    hiss_lvds_ctrl dut_a (
        .pclk      (pclk),
        .n_p_reset (n_p_reset),
        .bus       (ifa)
    );

    hiss_lvds_ctrl #(
        .BIAS_WAIT  (1),
        .CLK_WAIT   (1),
        .DRAIN_WAIT (1)
    ) dut_b (
        .pclk      (pclk),
        .n_p_reset (n_p_reset),
        .bus       (ifb)
    );

    logic [13:0] act_a;
    logic [13:0] act_b;
    assign act_a = {ifa.state, ifa.ready, ifa.up_done, ifa.down_done, ifa.hiss_biasen,
                    ifa.hiss_replien, ifa.hiss_curr, ifa.hiss_clken, ifa.hiss_rxien,
                    ifa.hiss_rxqen, ifa.hiss_txien, ifa.hiss_txqen};
    assign act_b = {ifb.state, ifb.ready, ifb.up_done, ifb.down_done, ifb.hiss_biasen,
                    ifb.hiss_replien, ifb.hiss_curr, ifb.hiss_clken, ifb.hiss_rxien,
                    ifb.hiss_rxqen, ifb.hiss_txien, ifb.hiss_txqen};

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Expected vector: state, ready, up_done, down_done, bias x3, clken, {rxi,rxq,txi,txq}.
    function automatic logic [13:0] ev(input logic [2:0] s, input logic r, input logic u,
                                       input logic d, input logic b, input logic c,
                                       input logic [3:0] en);
        return {s, r, u, d, b, b, b, c, en};
    endfunction

    task automatic checkOutput(input logic [13:0] act, input logic [13:0] exp_v, input string name);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic applyStimulus(input bit which, input logic en, input logic rxi, input logic rxq,
                                 input logic txi, input logic txq, input logic [13:0] exp_v,
                                 input string name);
        if (which == 1'b0) begin
            ifa.en_req = en; ifa.rx_i_req = rxi; ifa.rx_q_req = rxq;
            ifa.tx_i_req = txi; ifa.tx_q_req = txq;
            qa.push_back('{exp_v, name});
        end else begin
            ifb.en_req = en; ifb.rx_i_req = rxi; ifb.rx_q_req = rxq;
            ifb.tx_i_req = txi; ifb.tx_q_req = txq;
            qb.push_back('{exp_v, name});
        end
        @(negedge pclk);
    endtask

    task automatic upSequence(input string tag);
        for (int i = 0; i < 16; i++)
            applyStimulus(0, 1, (i == 3), (i == 9), (i == 7), 0,
                          ev(3'd1, 0, 0, 0, 1, 0, 4'b0000), $sformatf("%s_bias_%0d", tag, i));
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 1, 0, 0, 0, 0,
                          ev(3'd2, 0, 0, 0, 1, 1, 4'b0000), $sformatf("%s_clkup_%0d", tag, i));
        applyStimulus(0, 1, 0, 0, 0, 0, ev(3'd3, 1, 1, 0, 1, 1, 4'b0000), {tag, "_active_entry"});
    endtask

    task automatic drainSequence(input string tag);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 1, 1, 1, 1,
                          ev(3'd4, 0, 0, 0, 1, 1, 4'b0000), $sformatf("%s_drain_%0d", tag, i));
        applyStimulus(0, 0, 0, 0, 0, 0, ev(3'd0, 0, 0, 1, 0, 0, 4'b0000), {tag, "_off_down"});
        applyStimulus(0, 0, 0, 0, 0, 0, ev(3'd0, 0, 0, 0, 0, 0, 4'b0000), {tag, "_off_idle"});
    endtask

    always @(posedge pclk) begin
        exp_t e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            checkOutput(act_a, e.v, e.name);
        end
    end

    always @(posedge pclk) begin
        exp_t e;
        #1;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            checkOutput(act_b, e.v, {"b_", e.name});
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        n_p_reset   = 1'b0;
        ifa.en_req = 0; ifa.rx_i_req = 0; ifa.rx_q_req = 0; ifa.tx_i_req = 0; ifa.tx_q_req = 0;
        ifb.en_req = 0; ifb.rx_i_req = 0; ifb.rx_q_req = 0; ifb.tx_i_req = 0; ifb.tx_q_req = 0;
        @(negedge pclk);
        @(negedge pclk);
        checkOutput(act_a, ev(3'd0, 0, 0, 0, 0, 0, 4'b0000), "reset_a");
        checkOutput(act_b, ev(3'd0, 0, 0, 0, 0, 0, 4'b0000), "reset_b");
        n_p_reset = 1'b1;

        // Power-up with en_req high from the first edge; rx/tx requests toggled in BIAS are ignored.
        upSequence("pwr");
        applyStimulus(0, 1, 0, 0, 0, 0, ev(3'd3, 1, 0, 0, 1, 1, 4'b0000), "active_idle");
        applyStimulus(0, 1, 1, 0, 0, 1, ev(3'd3, 1, 0, 0, 1, 1, 4'b1001), "active_rxi_txq");
        applyStimulus(0, 1, 1, 0, 0, 1, ev(3'd3, 1, 0, 0, 1, 1, 4'b1001), "active_hold");
        applyStimulus(0, 1, 0, 1, 1, 0, ev(3'd3, 1, 0, 0, 1, 1, 4'b0110), "active_rxq_txi");
        applyStimulus(0, 1, 1, 1, 1, 1, ev(3'd3, 1, 0, 0, 1, 1, 4'b1111), "active_all");
        drainSequence("act");

        // Abort in the 5th BIAS cycle: straight to OFF with no down_done.
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 0, 0, 0, 0,
                          ev(3'd1, 0, 0, 0, 1, 0, 4'b0000), $sformatf("abort_bias_%0d", i));
        applyStimulus(0, 0, 1, 1, 0, 0, ev(3'd0, 0, 0, 0, 0, 0, 4'b0000), "abort_bias_off");
        applyStimulus(0, 0, 0, 0, 0, 0, ev(3'd0, 0, 0, 0, 0, 0, 4'b0000), "abort_bias_idle");

        // Abort in CLKUP: drains before OFF.
        for (int i = 0; i < 16; i++)
            applyStimulus(0, 1, 0, 0, 0, 0,
                          ev(3'd1, 0, 0, 0, 1, 0, 4'b0000), $sformatf("abort_clk_bias_%0d", i));
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 0, 0, 0, 0,
                          ev(3'd2, 0, 0, 0, 1, 1, 4'b0000), $sformatf("abort_clk_clkup_%0d", i));
        drainSequence("clk");

        // Re-request during DRAIN: drain completes, one OFF cycle, then a full power-up.
        upSequence("re1");
        applyStimulus(0, 0, 0, 0, 0, 0, ev(3'd4, 0, 0, 0, 1, 1, 4'b0000), "re_drain_0");
        for (int i = 1; i < 4; i++)
            applyStimulus(0, 1, 0, 0, 0, 0,
                          ev(3'd4, 0, 0, 0, 1, 1, 4'b0000), $sformatf("re_drain_%0d", i));
        applyStimulus(0, 1, 0, 0, 0, 0, ev(3'd0, 0, 0, 1, 0, 0, 4'b0000), "re_off_down");
        upSequence("re2");
        applyStimulus(0, 1, 1, 1, 0, 0, ev(3'd3, 1, 0, 0, 1, 1, 4'b1100), "re_active");

        // Asynchronous reset between edges while ACTIVE, then a full sequence again.
        #8;
        n_p_reset = 1'b0;
        #1;
        checkOutput(act_a, ev(3'd0, 0, 0, 0, 0, 0, 4'b0000), "async_reset");
        @(negedge pclk);
        @(negedge pclk);
        checkOutput(act_a, ev(3'd0, 0, 0, 0, 0, 0, 4'b0000), "reset_held");
        n_p_reset = 1'b1;
        upSequence("rst");
        applyStimulus(0, 0, 0, 0, 0, 0, ev(3'd4, 0, 0, 0, 1, 1, 4'b0000), "rst_drain");

        // All waits = 1: every timed state lasts exactly one cycle.
        applyStimulus(1, 1, 0, 0, 0, 0, ev(3'd1, 0, 0, 0, 1, 0, 4'b0000), "w1_bias");
        applyStimulus(1, 1, 0, 0, 0, 0, ev(3'd2, 0, 0, 0, 1, 1, 4'b0000), "w1_clkup");
        applyStimulus(1, 1, 0, 0, 0, 0, ev(3'd3, 1, 1, 0, 1, 1, 4'b0000), "w1_active");
        applyStimulus(1, 1, 1, 0, 0, 0, ev(3'd3, 1, 0, 0, 1, 1, 4'b1000), "w1_active_rxi");
        applyStimulus(1, 0, 1, 0, 0, 0, ev(3'd4, 0, 0, 0, 1, 1, 4'b0000), "w1_drain");
        applyStimulus(1, 0, 0, 0, 0, 0, ev(3'd0, 0, 0, 1, 0, 0, 4'b0000), "w1_off_down");
        applyStimulus(1, 1, 0, 0, 0, 0, ev(3'd1, 0, 0, 0, 1, 0, 4'b0000), "w1_bias2");
        applyStimulus(1, 0, 0, 0, 0, 0, ev(3'd0, 0, 0, 0, 0, 0, 4'b0000), "w1_abort_off");
        applyStimulus(1, 0, 0, 0, 0, 0, ev(3'd0, 0, 0, 0, 0, 0, 4'b0000), "w1_idle");

        for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++)
            @(negedge pclk);
        if (qa.size() > 0 || qb.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", qa.size() + qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
